// File: rtl/pipe_stage_buffer.sv
// rtl/pipe_stage_buffer.sv - registered FIFO pipeline stage with flush and bubble output
module pipe_stage_buffer #(
  parameter int                 WIDTH  = 32,
  parameter int                 DEPTH  = 2,
  parameter logic [WIDTH-1:0]   BUBBLE = '0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         valid_in,
  output logic                         ready_in,
  input  logic [WIDTH-1:0]             data_in,
  output logic                         valid_out,
  input  logic                         ready_out,
  output logic [WIDTH-1:0]             data_out,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  // A single-entry stage still needs a one-bit pointer to index storage.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic             push;
  logic             pop;

  // Handshake flags come only from the registered count, so ready_in never
  // depends combinationally on ready_out; a pop from full frees the slot
  // one cycle later.
  assign ready_in  = (count < FULL_CNT);
  assign valid_out = (count != '0);

  // Flush wins over both transfers in the same cycle.
  assign push = valid_in & ready_in & ~flush;
  assign pop  = valid_out & ready_out & ~flush;

  // Pointers wrap explicitly so non-power-of-two depths work.
  assign rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
  assign wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;

  assign data_out = valid_out ? mem[rd_ptr] : BUBBLE;

  // Pointer and occupancy state; reset and flush drop every held entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr_nxt;
      end
      if (pop) begin
        rd_ptr <= rd_ptr_nxt;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

endmodule

// File: doc/pipe_stage_buffer.md
PIPE_STAGE_BUFFER -- requirements
Module: pipe_stage_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 2, number of storage entries (>=1; DEPTH not required to be a power of 2).
REQ-003 SHALL have parameter BUBBLE, WIDTH bits, default all-zero, value presented on data_out when empty.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-007 SHALL have port valid_in  input  1  upstream offers data_in.
REQ-008 SHALL have port ready_in  output  1  stage accepts data_in this cycle.
REQ-009 SHALL have port data_in  input  WIDTH  upstream payload.
REQ-010 SHALL have port valid_out  output  1  data_out holds a valid entry.
REQ-011 SHALL have port ready_out  input  1  downstream accepts data_out this cycle.
REQ-012 SHALL have port data_out  output  WIDTH  oldest held entry, else BUBBLE.
REQ-013 SHALL have port count  output  $clog2(DEPTH+1)  number of held entries.

Function
REQ-014 SHALL perform push = valid_in & ready_in & ~flush; pop = valid_out & ready_out & ~flush.
REQ-015 SHALL drive ready_in = (count < DEPTH), derived from registered state only; no combinational path from ready_out or valid_in to ready_in.
REQ-016 SHALL drive valid_out = (count != 0), from registered state only.
REQ-017 SHALL drive data_out = entry at read pointer when count != 0, else BUBBLE.
REQ-018 SHALL store entries in FIFO order; data_out order SHALL equal push order, no loss, no duplication.
REQ-019 SHALL have latency of exactly 1 cycle: a push at edge N into an empty stage is visible on data_out/valid_out after edge N; no same-cycle bypass from data_in to data_out.
REQ-020 SHALL update count: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-021 SHALL, when full (count == DEPTH), deassert ready_in even if ready_out = 1 in that cycle; the pop frees a slot visible the following cycle.
REQ-022 SHALL, on simultaneous push and pop with 0 < count < DEPTH, write the new entry and retire the head in the same edge.
REQ-023 SHALL advance read/write pointers modulo DEPTH: pointer at DEPTH-1 wraps to 0.
REQ-024 SHALL, when flush = 1 at an edge, set count to 0 and pointers to 0; any concurrent valid_in is dropped and no pop is counted (flush has priority over push and pop).
REQ-025 SHALL NOT alter stored payloads or pointers when neither push, pop nor flush occurs (stall by backpressure holds state).
REQ-026 SHALL ignore data_in when valid_in = 0 and ignore ready_out when valid_out = 0.

Reset
REQ-027 SHALL, while reset_n = 0, immediately (asynchronously) force count = 0, pointers = 0, valid_out = 0, data_out = BUBBLE, ready_in = 1.
REQ-028 SHALL, on reset_n asserted mid-operation, discard all held entries; storage array contents need not be cleared.
REQ-029 SHALL accept a push on the first rising edge after reset_n deasserts.

Verification
REQ-030 SHALL pass: DEPTH=2, push 0xA1 with ready_out=1 -> next cycle valid_out=1, data_out=0xA1, count=1; following cycle with no push -> valid_out=0, data_out=BUBBLE.
REQ-031 SHALL pass: DEPTH=2, ready_out=0, push 0x11,0x22,0x33 on consecutive cycles -> count 1,2,2; ready_in=0 at third push; 0x33 not accepted; then ready_out=1 -> outputs 0x11 then 0x22.
REQ-032 SHALL pass: DEPTH=3, 10 pushes/pops of 0..9 with random ready_out -> output sequence 0..9 in order across pointer wrap.
REQ-033 SHALL pass: count=2, flush=1 with valid_in=1 data 0x55 -> next cycle count=0, valid_out=0, data_out=BUBBLE; 0x55 never appears.
REQ-034 SHALL pass: count=2, reset_n pulsed low between clock edges -> valid_out=0, count=0, ready_in=1 before next edge.
REQ-035 SHALL pass: full (DEPTH=2), valid_in=1, ready_out=1 same cycle -> head retired, no push that edge, count=1, ready_in=1 next cycle.
